freq_ratio_phase_sequencer: RTL and testbench
=============================================

Name: freq_ratio_phase_sequencer

Overview:
Controller for the DFI frequency-ratio serializer. It generates the per-clock phase select (p0..p3) and the bundle-capture strobe for the active ratio (1:1, 1:2 or 1:4). It also runs the DFI frequency-change handshake (dfi_init_start / dfi_init_complete): it drains in-flight write phases, switches the active ratio and restarts phase sequencing cleanly. It sits between the DFI interface and the serializer, in the write path of the PHY.

Parameters:
DRAIN_CYC, 4, cycles held muted after the last bundle before a ratio switch (range 1..15)
RESET_RATIO, 3'b010, active ratio code after reset (1:4)

Ports:
i_clock  in  1  PHY clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  sequencer enable
dfi_freq_ratio  in  3  requested ratio code: 3'b000 = 1:1, 3'b001 = 1:2, 3'b010 = 1:4; other codes are illegal
dfi_init_start  in  1  frequency-change request, level, held until complete
i_wrdata_en_any  in  1  OR of dfi_wrdata_en_p0..p3 for the bundle being captured
dfi_init_complete  out  1  frequency-change acknowledge
o_phase_sel  out  2  phase index driven to the serializer mux
o_bundle_start  out  1  serializer captures p0..p3 this cycle
o_mute  out  1  serializer drives idle (cs_n all 1, wrdata_en 0)
o_active_ratio  out  3  currently applied ratio code
o_ratio_err  out  1  sticky, set when an illegal ratio code is sampled

Behaviour:
- Reset (async assert, sync release) values:
  - state IDLE
  - o_phase_sel 0, o_bundle_start 0, o_mute 1, dfi_init_complete 0, o_ratio_err 0
  - o_active_ratio = RESET_RATIO
- All outputs are registered.
- N = phases per bundle = 1, 2 or 4, derived from o_active_ratio.
- IDLE:
  - o_mute 1, phase 0.
  - Each cycle, a legal dfi_freq_ratio is loaded into o_active_ratio. An illegal code keeps the old value and sets o_ratio_err.
  - i_enable=1 -> RUN.
- RUN:
  - First cycle: o_phase_sel=0, o_bundle_start=1, o_mute=0.
  - o_phase_sel increments each cycle and wraps at N-1 -> 0.
  - o_bundle_start=1 exactly when o_phase_sel=0.
  - For 1:1, o_bundle_start is high every cycle.
- Ratio change:
  - dfi_init_start sampled high in RUN -> the current bundle completes (through phase N-1) -> DRAIN.
  - If the request arrives on phase N-1, DRAIN is entered the next cycle.
- DRAIN:
  - o_mute 1, o_bundle_start 0, phase 0.
  - A 4-bit counter runs DRAIN_CYC cycles.
  - The counter reloads whenever i_wrdata_en_any=1, so drain finishes only after DRAIN_CYC consecutive idle cycles.
  - At terminal count -> SWITCH.
- SWITCH (1 cycle):
  - Sample dfi_freq_ratio. Legal -> load o_active_ratio. Illegal -> keep old value, set o_ratio_err.
  - -> ACK.
- ACK:
  - dfi_init_complete=1, o_mute 1.
  - Held until dfi_init_start is sampled low; then complete drops the next cycle and the block goes to RUN at phase 0 with bundle_start=1.
- i_enable=0 in any state -> IDLE next cycle, dfi_init_complete 0. An in-progress handshake is abandoned; the ratio loaded so far is kept.
- dfi_init_start high in IDLE: ignored. The ratio follows the IDLE tracking rule.
- dfi_freq_ratio changes in RUN without dfi_init_start: ignored.
- o_ratio_err clears only on reset.
- Async reset mid-handshake: all outputs return to reset values immediately, and o_active_ratio returns to RESET_RATIO.

Decomposition:
- Package freq_ratio_pkg holds:
  - state enum {IDLE, RUN, DRAIN, SWITCH, ACK}
  - ratio code constants RATIO_1_1, RATIO_1_2, RATIO_1_4
  - function ratio_to_phases(code) returning N
  - function ratio_legal(code)
- One sub-module is natural: freq_ratio_drain_counter (loadable 4-bit down-counter with reload and terminal flag).

Test Plan:
1. Reset release, i_enable=1, ratio 3'b010 -> RUN: o_phase_sel 0,1,2,3,0; o_bundle_start 1,0,0,0,1; o_mute 0 from the first RUN cycle.
2. Ratio 3'b001 in IDLE, then enable -> o_phase_sel alternates 0,1; bundle_start every second cycle. Ratio 3'b000 -> bundle_start constant 1, phase_sel 0.
3. In RUN at 1:4, raise dfi_init_start at phase 1 with new ratio 3'b001, i_wrdata_en_any=0 -> phases 2,3 complete, then 4 DRAIN cycles muted, 1 SWITCH, then complete=1. Drop init_start -> complete low, RUN at 1:2, phase 0.
4. During DRAIN, pulse i_wrdata_en_any for 1 cycle at drain cycle 2 -> drain extends so that 4 idle cycles follow the pulse before SWITCH.
5. Handshake with dfi_freq_ratio=3'b111 -> o_active_ratio stays 3'b010, o_ratio_err=1 sticky, complete still asserted.
6. Assert i_reset during ACK -> complete 0, o_mute 1, o_active_ratio 3'b010 immediately (asynchronous); a drop of i_enable during DRAIN -> IDLE next cycle.

Source files
------------

// File: rtl/freq_ratio_pkg.sv
// Shared types and helpers for the DFI frequency-ratio phase sequencer.
package freq_ratio_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        SWITCH = 3'd3,
        ACK    = 3'd4
    } state_e;

    localparam logic [2:0] RATIO_1_1 = 3'b000;
    localparam logic [2:0] RATIO_1_2 = 3'b001;
    localparam logic [2:0] RATIO_1_4 = 3'b010;

    // Phases per bundle; illegal codes never reach the active register,
    // so the fallback value is only a safe default.
    function automatic logic [2:0] ratio_to_phases(input logic [2:0] code);
        logic [2:0] n;
        case (code)
            RATIO_1_1: n = 3'd1;
            RATIO_1_2: n = 3'd2;
            RATIO_1_4: n = 3'd4;
            default:   n = 3'd1;
        endcase
        return n;
    endfunction

    function automatic logic ratio_legal(input logic [2:0] code);
        return (code == RATIO_1_1) || (code == RATIO_1_2) || (code == RATIO_1_4);
    endfunction

endpackage

// File: rtl/freq_ratio_drain_counter.sv
// Loadable 4-bit down-counter used to time the write drain before a
// ratio switch. Terminal flag marks the last counted cycle.
module freq_ratio_drain_counter
    import freq_ratio_pkg::*;
#(
    parameter logic [3:0] LOAD_VAL = 4'd4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic tc_o
);

    logic [3:0] cnt_q;

    // Load wins over decrement; count parks at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= LOAD_VAL;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign tc_o = (cnt_q == 4'd1);

endmodule

// File: rtl/freq_ratio_phase_sequencer.sv
// Phase select / bundle strobe generator for the DFI write serializer,
// including the dfi_init_start / dfi_init_complete frequency-change
// handshake.
//
// state  | meaning
// IDLE   | muted, active ratio tracks dfi_freq_ratio
// RUN    | phases cycle 0..N-1, bundle strobe on phase 0
// DRAIN  | muted until DRAIN_CYC consecutive cycles without write data
// SWITCH | sample requested ratio (one cycle)
// ACK    | complete asserted until dfi_init_start drops
module freq_ratio_phase_sequencer
    import freq_ratio_pkg::*;
#(
    parameter int unsigned DRAIN_CYC   = 4,
    parameter logic [2:0]  RESET_RATIO = 3'b010
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [2:0] dfi_freq_ratio,
    input  logic       dfi_init_start,
    input  logic       i_wrdata_en_any,
    output logic       dfi_init_complete,
    output logic [1:0] o_phase_sel,
    output logic       o_bundle_start,
    output logic       o_mute,
    output logic [2:0] o_active_ratio,
    output logic       o_ratio_err
);

    state_e     state_q;
    logic [1:0] phase_q;
    logic       bundle_q;
    logic       mute_q;
    logic       complete_q;
    logic [2:0] ratio_q;
    logic       err_q;
    logic       pend_q;

    logic [1:0] last_phase;
    logic       ratio_ok;
    logic       drain_load;
    logic       drain_dec;
    logic       drain_tc;

    assign last_phase = 2'(ratio_to_phases(ratio_q) - 3'd1);
    assign ratio_ok   = ratio_legal(dfi_freq_ratio);

    // Counter sits preloaded outside DRAIN, so it is full on DRAIN entry;
    // any write activity inside DRAIN restarts the idle window.
    assign drain_load = (state_q != DRAIN) || i_wrdata_en_any;
    assign drain_dec  = (state_q == DRAIN);

    freq_ratio_drain_counter #(
        .LOAD_VAL (4'(DRAIN_CYC))
    ) u_drain_cnt (
        .clk_i  (i_clock),
        .rst_i  (i_reset),
        .load_i (drain_load),
        .dec_i  (drain_dec),
        .tc_o   (drain_tc)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            phase_q    <= 2'd0;
            bundle_q   <= 1'b0;
            mute_q     <= 1'b1;
            complete_q <= 1'b0;
            ratio_q    <= RESET_RATIO;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else if (!i_enable) begin
            state_q    <= IDLE;
            phase_q    <= 2'd0;
            bundle_q   <= 1'b0;
            mute_q     <= 1'b1;
            complete_q <= 1'b0;
            pend_q     <= 1'b0;
            if (state_q == IDLE) begin
                if (ratio_ok) ratio_q <= dfi_freq_ratio;
                else          err_q   <= 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ratio_ok) ratio_q <= dfi_freq_ratio;
                    else          err_q   <= 1'b1;
                    state_q  <= RUN;
                    phase_q  <= 2'd0;
                    bundle_q <= 1'b1;
                    mute_q   <= 1'b0;
                    pend_q   <= 1'b0;
                end
                RUN: begin
                    if ((phase_q == last_phase) && (pend_q || dfi_init_start)) begin
                        state_q  <= DRAIN;
                        phase_q  <= 2'd0;
                        bundle_q <= 1'b0;
                        mute_q   <= 1'b1;
                        pend_q   <= 1'b0;
                    end else begin
                        pend_q   <= pend_q || dfi_init_start;
                        phase_q  <= (phase_q == last_phase) ? 2'd0 : phase_q + 2'd1;
                        bundle_q <= (phase_q == last_phase);
                    end
                end
                DRAIN: begin
                    if (drain_tc && !i_wrdata_en_any) state_q <= SWITCH;
                end
                SWITCH: begin
                    if (ratio_ok) ratio_q <= dfi_freq_ratio;
                    else          err_q   <= 1'b1;
                    state_q    <= ACK;
                    complete_q <= 1'b1;
                end
                ACK: begin
                    if (!dfi_init_start) begin
                        state_q    <= RUN;
                        complete_q <= 1'b0;
                        phase_q    <= 2'd0;
                        bundle_q   <= 1'b1;
                        mute_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    phase_q    <= 2'd0;
                    bundle_q   <= 1'b0;
                    mute_q     <= 1'b1;
                    complete_q <= 1'b0;
                    pend_q     <= 1'b0;
                end
            endcase
        end
    end

    assign dfi_init_complete = complete_q;
    assign o_phase_sel       = phase_q;
    assign o_bundle_start    = bundle_q;
    assign o_mute            = mute_q;
    assign o_active_ratio    = ratio_q;
    assign o_ratio_err       = err_q;

endmodule

// File: tb/tb_freq_ratio_phase_sequencer.sv
// Directed bench for freq_ratio_phase_sequencer: cycle-by-cycle vector
// table plus hand sequences for async reset in ACK.
module tb_freq_ratio_phase_sequencer;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       en     = 1'b0;
    logic [2:0] ratio  = 3'b010;
    logic       init   = 1'b0;
    logic       wr     = 1'b0;
    logic       cmpl;
    logic [1:0] psel;
    logic       bstart;
    logic       mute;
    logic [2:0] aratio;
    logic       rerr;

    int n_cmp = 0;
    int n_bad = 0;

    freq_ratio_phase_sequencer #(
        .DRAIN_CYC   (4),
        .RESET_RATIO (3'b010)
    ) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_enable          (en),
        .dfi_freq_ratio    (ratio),
        .dfi_init_start    (init),
        .i_wrdata_en_any   (wr),
        .dfi_init_complete (cmpl),
        .o_phase_sel       (psel),
        .o_bundle_start    (bstart),
        .o_mute            (mute),
        .o_active_ratio    (aratio),
        .o_ratio_err       (rerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] ratio;
        logic       init;
        logic       wr;
        logic [8:0] exp;   // {phase, bundle, mute, complete, ratio, err}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic e, input logic [2:0] r, input logic i,
                                input logic w, input logic [1:0] p, input logic b,
                                input logic m, input logic c, input logic [2:0] ar,
                                input logic er);
        vec_t v;
        v.en = e; v.ratio = r; v.init = i; v.wr = w;
        v.exp = {p, b, m, c, ar, er};
        vecs.push_back(v);
    endfunction

    function automatic logic [8:0] outs();
        return {psel, bstart, mute, cmpl, aratio, rerr};
    endfunction

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got p=%0d bs=%0b mute=%0b cmpl=%0b ratio=%03b err=%0b, want p=%0d bs=%0b mute=%0b cmpl=%0b ratio=%03b err=%0b",
                     nm, act[8:7], act[6], act[5], act[4], act[3:1], act[0],
                     exp[8:7], exp[6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic check1(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03b, want %03b", nm, act, exp);
        end
    endtask

    initial begin
        //  en  ratio  init wr   p  bs mu cm ratio  er
        // 1:4 start-up
        add(1, 3'b010, 0, 0, 0, 1, 0, 0, 3'b010, 0);
        add(1, 3'b010, 0, 0, 1, 0, 0, 0, 3'b010, 0);
        add(1, 3'b010, 0, 0, 2, 0, 0, 0, 3'b010, 0);
        add(1, 3'b010, 0, 0, 3, 0, 0, 0, 3'b010, 0);
        add(1, 3'b010, 0, 0, 0, 1, 0, 0, 3'b010, 0);
        add(1, 3'b010, 0, 0, 1, 0, 0, 0, 3'b010, 0);
        // request at phase 1, switch to 1:2, clean drain of 4 cycles
        add(1, 3'b001, 1, 0, 2, 0, 0, 0, 3'b010, 0);
        add(1, 3'b001, 1, 0, 3, 0, 0, 0, 3'b010, 0);
        add(1, 3'b001, 1, 0, 0, 0, 1, 0, 3'b010, 0);
        add(1, 3'b001, 1, 0, 0, 0, 1, 0, 3'b010, 0);
        add(1, 3'b001, 1, 0, 0, 0, 1, 0, 3'b010, 0);
        add(1, 3'b001, 1, 0, 0, 0, 1, 0, 3'b010, 0);
        add(1, 3'b001, 1, 0, 0, 0, 1, 0, 3'b010, 0);   // SWITCH
        add(1, 3'b001, 1, 0, 0, 0, 1, 1, 3'b001, 0);   // ACK
        add(1, 3'b001, 1, 0, 0, 0, 1, 1, 3'b001, 0);
        add(1, 3'b001, 0, 0, 0, 1, 0, 0, 3'b001, 0);   // back to RUN at 1:2
        add(1, 3'b001, 0, 0, 1, 0, 0, 0, 3'b001, 0);
        add(1, 3'b001, 0, 0, 0, 1, 0, 0, 3'b001, 0);
        add(1, 3'b001, 0, 0, 1, 0, 0, 0, 3'b001, 0);
        // request on last phase with illegal code; write pulse at drain cycle 2
        add(1, 3'b111, 1, 0, 0, 0, 1, 0, 3'b001, 0);
        add(1, 3'b111, 1, 0, 0, 0, 1, 0, 3'b001, 0);
        add(1, 3'b111, 1, 1, 0, 0, 1, 0, 3'b001, 0);
        add(1, 3'b111, 1, 0, 0, 0, 1, 0, 3'b001, 0);
        add(1, 3'b111, 1, 0, 0, 0, 1, 0, 3'b001, 0);
        add(1, 3'b111, 1, 0, 0, 0, 1, 0, 3'b001, 0);
        add(1, 3'b111, 1, 0, 0, 0, 1, 0, 3'b001, 0);   // SWITCH
        add(1, 3'b111, 1, 0, 0, 0, 1, 1, 3'b001, 1);   // ACK, error sticky
        add(1, 3'b111, 1, 0, 0, 0, 1, 1, 3'b001, 1);
        add(1, 3'b111, 0, 0, 0, 1, 0, 0, 3'b001, 1);
        add(1, 3'b000, 0, 0, 1, 0, 0, 0, 3'b001, 1);   // ratio change in RUN ignored
        // disable, pick 1:1 in IDLE
        add(0, 3'b000, 0, 0, 0, 0, 1, 0, 3'b001, 1);
        add(0, 3'b000, 0, 0, 0, 0, 1, 0, 3'b000, 1);
        add(1, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 1);
        add(1, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 1);
        add(1, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 1);
        // 1:1 handshake to 1:4
        add(1, 3'b010, 1, 0, 0, 0, 1, 0, 3'b000, 1);
        add(1, 3'b010, 1, 0, 0, 0, 1, 0, 3'b000, 1);
        add(1, 3'b010, 1, 0, 0, 0, 1, 0, 3'b000, 1);
        add(1, 3'b010, 1, 0, 0, 0, 1, 0, 3'b000, 1);
        add(1, 3'b010, 1, 0, 0, 0, 1, 0, 3'b000, 1);   // SWITCH
        add(1, 3'b010, 1, 0, 0, 0, 1, 1, 3'b010, 1);   // ACK
        add(1, 3'b010, 0, 0, 0, 1, 0, 0, 3'b010, 1);
        add(1, 3'b010, 0, 0, 1, 0, 0, 0, 3'b010, 1);
        // enable drop while draining
        add(1, 3'b010, 1, 0, 2, 0, 0, 0, 3'b010, 1);
        add(1, 3'b010, 1, 0, 3, 0, 0, 0, 3'b010, 1);
        add(1, 3'b010, 1, 0, 0, 0, 1, 0, 3'b010, 1);   // DRAIN
        add(0, 3'b010, 1, 0, 0, 0, 1, 0, 3'b010, 1);   // IDLE
        add(0, 3'b101, 0, 0, 0, 0, 1, 0, 3'b010, 1);   // illegal in IDLE keeps ratio

        #1 rst = 1'b1;
        #2 check("reset_values", outs(), {2'd0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en    = vecs[i].en;
            ratio = vecs[i].ratio;
            init  = vecs[i].init;
            wr    = vecs[i].wr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // async reset clears the sticky error immediately
        rst = 1'b1;
        #1 check("reset_clears_err", outs(), {2'd0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0});
        @(negedge clk);
        rst   = 1'b0;
        init  = 1'b0;
        en    = 1'b1;
        ratio = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        init  = 1'b1;
        ratio = 3'b001;
        begin
            int k;
            for (k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (cmpl === 1'b1) break;
            end
            check1("ack_reached", {2'b00, cmpl}, 3'b001);
            check1("ack_ratio", aratio, 3'b001);
        end
        // reset mid-cycle while in ACK, checked before the next edge
        #2 rst = 1'b1;
        #1 check("reset_in_ack", outs(), {2'd0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0});
        @(negedge clk);
        rst  = 1'b0;
        init = 1'b0;
        ratio = 3'b010;
        @(posedge clk);
        #1 check("restart_after_reset", outs(), {2'd0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
